battleship_engine: RTL and testbench

Parametrised game-state engine for the battleship design: holds both players' boards, per-ship damage counters and remaining-ship counts, and runs the setup/aim/fire/turn-swap/game-over sequence. It sits between the debounced, edge-detected button pulses and the SSD/VGA display blocks. It replaces fixed-size boards and constant scores with a configurable grid, configurable fleet size and a real turn state machine.

---
 rtl/battleship_engine_if.sv | 40 ++++
 rtl/battleship_engine.sv | 182 ++++++++++++++++++
 tb/tb_battleship_engine.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/battleship_engine_if.sv
// Signal bundle between the battleship engine and its surroundings: button
// pulses and the setup write port in, board/score/cursor/turn status out.
interface battleship_engine_if #(
  parameter int GRID_W    = 10,
  parameter int GRID_H    = 10,
  parameter int NUM_SHIPS = 5
);
  localparam int XW    = $clog2(GRID_W);
  localparam int YW    = $clog2(GRID_H);
  localparam int IDW   = $clog2(NUM_SHIPS + 1);
  localparam int CELLS = GRID_W * GRID_H;

  logic               btn_c, btn_l, btn_r, btn_u, btn_d;
  logic               load_we;
  logic               load_player;
  logic [XW-1:0]      load_x;
  logic [YW-1:0]      load_y;
  logic [IDW-1:0]     load_id;
  logic [IDW-1:0]     p1_ships, p2_ships;
  logic [2*CELLS-1:0] p1_board, p2_board;
  logic [XW-1:0]      cursor_x;
  logic [YW-1:0]      cursor_y;
  logic               turn;
  logic               game_over;
  logic               winner;

  modport master (
    output btn_c, btn_l, btn_r, btn_u, btn_d,
    output load_we, load_player, load_x, load_y, load_id,
    input  p1_ships, p2_ships, p1_board, p2_board,
    input  cursor_x, cursor_y, turn, game_over, winner
  );

  modport slave (
    input  btn_c, btn_l, btn_r, btn_u, btn_d,
    input  load_we, load_player, load_x, load_y, load_id,
    output p1_ships, p2_ships, p1_board, p2_board,
    output cursor_x, cursor_y, turn, game_over, winner
  );
endinterface

// File: rtl/battleship_engine.sv
// Battleship game-state engine: both boards, per-ship remaining lengths, fleet
// counts, and the setup / aim / resolve / swap / game-over turn sequence.
module battleship_engine #(
  parameter int GRID_W    = 10,
  parameter int GRID_H    = 10,
  parameter int NUM_SHIPS = 5,
  parameter int LEN_W     = 3
) (
  input logic                clk,
  input logic                rst,
  battleship_engine_if.slave bus
);
  localparam int XW    = $clog2(GRID_W);
  localparam int YW    = $clog2(GRID_H);
  localparam int IDW   = $clog2(NUM_SHIPS + 1);
  localparam int CELLS = GRID_W * GRID_H;
  localparam int CW    = $clog2(CELLS);

  localparam logic [XW:0]    X_LIM  = (XW + 1)'(GRID_W);
  localparam logic [YW:0]    Y_LIM  = (YW + 1)'(GRID_H);
  localparam logic [XW-1:0]  X_MAX  = XW'(GRID_W - 1);
  localparam logic [YW-1:0]  Y_MAX  = YW'(GRID_H - 1);
  localparam logic [IDW-1:0] ID_MAX = IDW'(NUM_SHIPS);

  typedef enum logic [2:0] {
    ST_SETUP,
    ST_AIM,
    ST_RESOLVE,
    ST_SWAP,
    ST_OVER
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   id_q    [2][CELLS];
  logic [IDW-1:0]   id_d    [2][CELLS];
  logic [CELLS-1:0] shot_q  [2];
  logic [CELLS-1:0] shot_d  [2];
  logic [LEN_W-1:0] len_q   [2][NUM_SHIPS+1];
  logic [LEN_W-1:0] len_d   [2][NUM_SHIPS+1];
  logic [IDW-1:0]   ships_q [2];
  logic [IDW-1:0]   ships_d [2];
  logic [XW-1:0]    cur_x_q, cur_x_d;
  logic [YW-1:0]    cur_y_q, cur_y_d;
  logic             turn_q, turn_d;
  logic             winner_q, winner_d;

  logic             lp;
  logic [IDW-1:0]   lid;
  logic [CW-1:0]    load_idx;
  logic [CW-1:0]    tgt_idx;
  logic [IDW-1:0]   tgt_id;
  logic             dfn;
  logic             load_ok;
  logic             move_en;

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    shot_d   = shot_q;
    len_d    = len_q;
    ships_d  = ships_q;
    cur_x_d  = cur_x_q;
    cur_y_d  = cur_y_q;
    turn_d   = turn_q;
    winner_d = winner_q;

    lp       = bus.load_player;
    lid      = bus.load_id;
    load_idx = CW'(bus.load_y) * CW'(GRID_W) + CW'(bus.load_x);
    dfn      = ~turn_q;
    tgt_idx  = CW'(cur_y_q) * CW'(GRID_W) + CW'(cur_x_q);
    tgt_id   = id_q[dfn][tgt_idx];

    // Range checks come first so out-of-grid coordinates never select a cell.
    load_ok = bus.load_we && (state_q == ST_SETUP) &&
              (lid != '0) && (lid <= ID_MAX) &&
              ({1'b0, bus.load_x} < X_LIM) && ({1'b0, bus.load_y} < Y_LIM) &&
              (id_q[lp][load_idx] == '0) && (len_q[lp][lid] != '1);

    move_en = ((state_q == ST_SETUP) || (state_q == ST_AIM)) && !bus.btn_c;

    if (load_ok) begin
      id_d[lp][load_idx] = lid;
      len_d[lp][lid]     = len_q[lp][lid] + 1'b1;
      if (len_q[lp][lid] == '0) ships_d[lp] = ships_q[lp] + 1'b1;
    end

    if (move_en) begin
      if (bus.btn_l)      cur_x_d = (cur_x_q == '0)    ? X_MAX : cur_x_q - 1'b1;
      else if (bus.btn_r) cur_x_d = (cur_x_q == X_MAX) ? '0    : cur_x_q + 1'b1;
      else if (bus.btn_u) cur_y_d = (cur_y_q == '0)    ? Y_MAX : cur_y_q - 1'b1;
      else if (bus.btn_d) cur_y_d = (cur_y_q == Y_MAX) ? '0    : cur_y_q + 1'b1;
    end

    unique case (state_q)
      ST_SETUP: begin
        if (bus.btn_c && (ships_q[0] != '0) && (ships_q[1] != '0)) begin
          state_d = ST_AIM;
          turn_d  = 1'b0;
        end
      end
      ST_AIM: begin
        if (bus.btn_c && !shot_q[dfn][tgt_idx]) state_d = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        shot_d[dfn][tgt_idx] = 1'b1;
        state_d              = ST_SWAP;
        if (tgt_id != '0) begin
          len_d[dfn][tgt_id] = len_q[dfn][tgt_id] - 1'b1;
          if (len_q[dfn][tgt_id] == LEN_W'(1)) begin
            ships_d[dfn] = ships_q[dfn] - 1'b1;
            if (ships_q[dfn] == IDW'(1)) begin
              state_d  = ST_OVER;
              winner_d = turn_q;
            end
          end
        end
      end
      ST_SWAP: begin
        turn_d  = ~turn_q;
        state_d = ST_AIM;
      end
      ST_OVER: begin
        if (bus.btn_c) begin
          state_d  = ST_SETUP;
          id_d     = '{default: '0};
          shot_d   = '{default: '0};
          len_d    = '{default: '0};
          ships_d  = '{default: '0};
          cur_x_d  = '0;
          cur_y_d  = '0;
          turn_d   = 1'b0;
          winner_d = 1'b0;
        end
      end
      default: state_d = ST_SETUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_SETUP;
      id_q     <= '{default: '0};
      shot_q   <= '{default: '0};
      len_q    <= '{default: '0};
      ships_q  <= '{default: '0};
      cur_x_q  <= '0;
      cur_y_q  <= '0;
      turn_q   <= 1'b0;
      winner_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      shot_q   <= shot_d;
      len_q    <= len_d;
      ships_q  <= ships_d;
      cur_x_q  <= cur_x_d;
      cur_y_q  <= cur_y_d;
      turn_q   <= turn_d;
      winner_q <= winner_d;
    end
  end

  // Cell code is {shot, occupied}: 00 water, 01 ship, 10 miss, 11 hit.
  logic [CELLS-1:0][1:0] board_w [2];

  for (genvar p = 0; p < 2; p++) begin : g_player
    for (genvar c = 0; c < CELLS; c++) begin : g_cell
      assign board_w[p][c] = {shot_q[p][c], (id_q[p][c] != '0)};
    end
  end

  assign bus.p1_board  = board_w[0];
  assign bus.p2_board  = board_w[1];
  assign bus.p1_ships  = ships_q[0];
  assign bus.p2_ships  = ships_q[1];
  assign bus.cursor_x  = cur_x_q;
  assign bus.cursor_y  = cur_y_q;
  assign bus.turn      = turn_q;
  assign bus.game_over = (state_q == ST_OVER);
  assign bus.winner    = winner_q;
endmodule

// File: tb/tb_battleship_engine.sv
// Bench for battleship_engine: a game-rules model tracks both fleets and is
// compared against every output each cycle, under directed and random play.
module tb_battleship_engine;
  localparam int GW    = 10;
  localparam int GH    = 10;
  localparam int NS    = 5;
  localparam int LW    = 3;
  localparam int CELLS = GW * GH;
  localparam int LMAX  = (1 << LW) - 1;

  localparam int M_SETUP = 0;
  localparam int M_AIM   = 1;
  localparam int M_RES   = 2;
  localparam int M_SWAP  = 3;
  localparam int M_OVER  = 4;

  logic clk = 1'b0;
  logic rst;

  battleship_engine_if #(.GRID_W(GW), .GRID_H(GH), .NUM_SHIPS(NS)) bif ();

  battleship_engine #(
    .GRID_W(GW), .GRID_H(GH), .NUM_SHIPS(NS), .LEN_W(LW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Game model: what each player has placed, where they have been shot,
  // how much of each ship is still afloat, and whose move it is.
  int mid   [2][CELLS];
  bit mshot [2][CELLS];
  int mlen  [2][NS+1];
  int mships[2];
  int mcx, mcy, mturn, mwin, mode;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_board(input string nm, input logic [2*CELLS-1:0] act,
                           input logic [2*CELLS-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < CELLS; c++) begin
        mid[p][c]   = 0;
        mshot[p][c] = 1'b0;
      end
      for (int s = 0; s <= NS; s++) mlen[p][s] = 0;
      mships[p] = 0;
    end
    mcx = 0; mcy = 0; mturn = 0; mwin = 0;
  endtask

  task automatic move_cursor();
    if (bif.btn_l)      mcx = (mcx + GW - 1) % GW;
    else if (bif.btn_r) mcx = (mcx + 1) % GW;
    else if (bif.btn_u) mcy = (mcy + GH - 1) % GH;
    else if (bif.btn_d) mcy = (mcy + 1) % GH;
  endtask

  task automatic place();
    int p, x, y, id, c;
    p = int'(bif.load_player); x = int'(bif.load_x);
    y = int'(bif.load_y);      id = int'(bif.load_id);
    if (x < GW && y < GH && id >= 1 && id <= NS) begin
      c = y * GW + x;
      if (mid[p][c] == 0 && mlen[p][id] < LMAX) begin
        if (mlen[p][id] == 0) mships[p]++;
        mlen[p][id]++;
        mid[p][c] = id;
      end
    end
  endtask

  task automatic model_step();
    int d, c, id;
    d = 1 - mturn;
    c = mcy * GW + mcx;
    if (rst) begin
      model_clear();
      mode = M_SETUP;
    end else begin
      case (mode)
        M_SETUP: begin
          if (bif.btn_c) begin
            if (mships[0] > 0 && mships[1] > 0) begin mode = M_AIM; mturn = 0; end
          end else move_cursor();
          if (bif.load_we) place();
        end
        M_AIM: begin
          if (bif.btn_c) begin
            if (!mshot[d][c]) mode = M_RES;
          end else move_cursor();
        end
        M_RES: begin
          mshot[d][c] = 1'b1;
          mode = M_SWAP;
          id = mid[d][c];
          if (id != 0) begin
            mlen[d][id]--;
            if (mlen[d][id] == 0) begin
              mships[d]--;
              if (mships[d] == 0) begin mode = M_OVER; mwin = mturn; end
            end
          end
        end
        M_SWAP: begin mturn = 1 - mturn; mode = M_AIM; end
        default: if (bif.btn_c) begin model_clear(); mode = M_SETUP; end
      endcase
    end
  endtask

  function automatic logic [1:0] cell_code(input int p, input int c);
    if (mid[p][c] == 0) return mshot[p][c] ? 2'd2 : 2'd0;
    else                return mshot[p][c] ? 2'd3 : 2'd1;
  endfunction

  always @(negedge clk) begin
    logic [2*CELLS-1:0] e0, e1;
    if (chk_en) begin
      for (int c = 0; c < CELLS; c++) begin
        e0[2*c +: 2] = cell_code(0, c);
        e1[2*c +: 2] = cell_code(1, c);
      end
      chk_board("p1_board", bif.p1_board, e0);
      chk_board("p2_board", bif.p2_board, e1);
      chk("p1_ships", 64'(bif.p1_ships), 64'(mships[0]));
      chk("p2_ships", 64'(bif.p2_ships), 64'(mships[1]));
      chk("cursor_x", 64'(bif.cursor_x), 64'(mcx));
      chk("cursor_y", 64'(bif.cursor_y), 64'(mcy));
      chk("turn", 64'(bif.turn), 64'(mturn));
      chk("game_over", 64'(bif.game_over), 64'(mode == M_OVER));
      if (mode == M_OVER) chk("winner", 64'(bif.winner), 64'(mwin));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clr();
    bif.btn_c = 1'b0; bif.btn_l = 1'b0; bif.btn_r = 1'b0;
    bif.btn_u = 1'b0; bif.btn_d = 1'b0;
    bif.load_we = 1'b0; bif.load_player = 1'b0;
    bif.load_x = '0; bif.load_y = '0; bif.load_id = '0;
  endtask

  // b: 0=C 1=L 2=R 3=U 4=D
  task automatic press(input int b);
    clr();
    case (b)
      0: bif.btn_c = 1'b1;
      1: bif.btn_l = 1'b1;
      2: bif.btn_r = 1'b1;
      3: bif.btn_u = 1'b1;
      default: bif.btn_d = 1'b1;
    endcase
    tick();
    clr();
  endtask

  task automatic load(input int p, input int x, input int y, input int id);
    clr();
    bif.load_we = 1'b1; bif.load_player = 1'(p);
    bif.load_x = 4'(x); bif.load_y = 4'(y); bif.load_id = 3'(id);
    tick();
    clr();
  endtask

  initial begin
    rst = 1'b1;
    clr();
    mode = M_SETUP;
    model_clear();
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    chk("lit_rst_cursor_x", 64'(bif.cursor_x), 64'(0));
    chk("lit_rst_ships", 64'({bif.p1_ships, bif.p2_ships}), 64'(0));
    chk("lit_rst_board", 64'(bif.p1_board[63:0] | bif.p2_board[63:0]), 64'(0));
    chk("lit_rst_over", 64'({bif.game_over, bif.turn}), 64'(0));

    press(1); chk("lit_wrap_l", 64'(bif.cursor_x), 64'(9));
    press(3); chk("lit_wrap_u", 64'(bif.cursor_y), 64'(9));
    press(2); chk("lit_wrap_r", 64'(bif.cursor_x), 64'(0));

    load(0, 0, 0, 1); load(0, 0, 0, 2); load(0, 1, 0, 1);
    load(0, 12, 0, 3); load(0, 2, 0, 0); load(0, 3, 0, 6);
    chk("lit_setup_ships", 64'(bif.p1_ships), 64'(1));
    chk("lit_setup_cells", 64'(bif.p1_board[7:0]), 64'(8'b0000_0101));
    press(0);
    load(1, 0, 0, 1); load(1, 1, 0, 1);
    chk("lit_still_setup", 64'(bif.p2_ships), 64'(1));

    press(0);
    press(4); chk("lit_wrap_d", 64'(bif.cursor_y), 64'(0));
    press(0); tick();
    chk("lit_hit_cell", 64'(bif.p2_board[1:0]), 64'(2'b11));
    chk("lit_hit_ships", 64'(bif.p2_ships), 64'(1));
    chk("lit_hit_turn_k1", 64'(bif.turn), 64'(0));
    tick();
    chk("lit_hit_turn_k2", 64'(bif.turn), 64'(1));

    press(2); press(2); press(0); tick();
    chk("lit_miss_cell", 64'(bif.p1_board[5:4]), 64'(2'b10));
    tick();
    press(0); tick(); tick();
    press(0); tick(); tick();
    chk("lit_repeat_turn", 64'(bif.turn), 64'(1));
    press(2); press(0); tick(); tick();

    press(1); press(1);
    clr(); bif.btn_c = 1'b1; bif.btn_l = 1'b1; tick(); clr(); tick();
    chk("lit_sink_ships", 64'(bif.p2_ships), 64'(0));
    chk("lit_sink_over", 64'(bif.game_over), 64'(1));
    chk("lit_sink_winner", 64'(bif.winner), 64'(0));
    chk("lit_prio_cursor", 64'(bif.cursor_x), 64'(1));

    press(1); press(3); load(0, 5, 5, 3);
    chk("lit_over_cursor", 64'(bif.cursor_x), 64'(1));
    chk("lit_over_load", 64'(bif.p1_board[111:110]), 64'(0));
    press(0);
    chk("lit_restart_over", 64'(bif.game_over), 64'(0));
    chk("lit_restart_board", 64'(bif.p2_board[7:0]), 64'(0));

    load(0, 0, 0, 1); load(1, 0, 0, 1); load(1, 1, 0, 1);
    press(0);
    clr(); bif.btn_c = 1'b1; tick(); clr();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("lit_rst_resolve_cell", 64'(bif.p2_board[1:0]), 64'(0));
    chk("lit_rst_resolve_ships", 64'(bif.p2_ships), 64'(0));

    for (int i = 0; i < 6000; i++) begin
      clr();
      rst = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 1) == 1) begin
        bif.load_we = 1'b1;
        bif.load_player = 1'($urandom_range(0, 1));
        bif.load_x = 4'($urandom_range(0, 15));
        bif.load_y = 4'($urandom_range(0, 15));
        bif.load_id = 3'($urandom_range(0, 7));
      end
      if (mode == M_SETUP) bif.btn_c = ($urandom_range(0, 39) == 0);
      else                 bif.btn_c = ($urandom_range(0, 3) == 0);
      bif.btn_l = ($urandom_range(0, 3) == 0);
      bif.btn_r = ($urandom_range(0, 3) == 0);
      bif.btn_u = ($urandom_range(0, 3) == 0);
      bif.btn_d = ($urandom_range(0, 3) == 0);
      tick();
    end
    clr();
    rst = 1'b0;
    tick();
    tick();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
